dcache_sa: RTL and testbench
============================

Name: dcache_sa

Overview:
- Parametrised successor to the single-configuration data cache between the pipeline MEM stage (p1_* interface) and the 256-bit off-chip Data Memory (mem_* interface).
- Write-back, write-allocate, N-way set-associative with true-LRU replacement.
- Set count, way count and line width are configurable.
- Adds hit/miss performance counters.

Parameters:
- WAYS, 2, associativity; power of 2, 1..8 (1 = direct-mapped).
- SETS, 16, sets per way; power of 2, >=2.
- LINE_BITS, 256, line width and mem data width; power of 2, 64..512.
- ADDR_W, 32, byte-address width.
- CNT_W, 32, width of each performance counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- p1_addr_i  in  ADDR_W  byte address from CPU.
- p1_data_i  in  32  store data.
- p1_MemRead_i  in  1  load request.
- p1_MemWrite_i  in  1  store request.
- p1_data_o  out  32  load data.
- p1_stall_o  out  1  CPU must hold the request and freeze the pipeline.
- mem_data_i  in  LINE_BITS  refill line.
- mem_ack_i  in  1  one-cycle completion pulse from memory.
- mem_data_o  out  LINE_BITS  write-back line.
- mem_addr_o  out  ADDR_W  line-aligned memory address.
- mem_enable_o  out  1  memory request valid.
- mem_write_o  out  1  1 = write-back, 0 = refill.
- hit_count_o  out  CNT_W  saturating hit counter.
- miss_count_o  out  CNT_W  saturating miss counter.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_i is asynchronous, active-high.
- Address split:
  - OFF = log2(LINE_BITS/8).
  - IDX = log2(SETS).
  - tag = addr[ADDR_W-1:OFF+IDX], index = addr[OFF+IDX-1:OFF], word = addr[OFF-1:2].
  - addr[1:0] are ignored.
- Per-way state per set: valid, dirty, tag, line, age (log2(WAYS) bits; omitted when WAYS=1).
- Reset (immediate, asynchronous):
  - FSM to IDLE; all valid and dirty bits cleared.
  - Ages set to way index.
  - Counters cleared; replay flag cleared.
  - Outputs: p1_stall_o=0, p1_data_o=0, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
- Request: p1_MemRead_i | p1_MemWrite_i. When both are high, the request is treated as a store.
- Hit: any way with valid and tag match in the indexed set. Multiple matches cannot occur.
- FSM states: IDLE, WRITEBACK, GAP, REFILL.
- IDLE, hit:
  - p1_stall_o=0 combinationally.
  - Load: p1_data_o = selected word, same cycle.
  - Store: word replaced and dirty set at the next edge.
  - LRU update at the edge.
  - hit_count_o += 1 unless the replay flag is set; the replay flag is then cleared.
- IDLE, miss:
  - p1_stall_o=1 combinationally.
  - Victim = lowest-index invalid way; else the way with age = WAYS-1.
  - At the edge: miss_count_o += 1, set the replay flag, latch victim way and request tag.
  - Go to WRITEBACK if the victim is valid and dirty, else REFILL.
- WRITEBACK:
  - mem_enable_o=1, mem_write_o=1, mem_addr_o = {victim tag, index, OFF zeros}, mem_data_o = victim line.
  - Held stable until mem_ack_i, then go to GAP.
- GAP: one cycle with mem_enable_o=0, then go to REFILL.
- REFILL:
  - mem_enable_o=1, mem_write_o=0, mem_addr_o = {request tag, index, OFF zeros}.
  - On mem_ack_i: victim line = mem_data_i, tag = request tag, valid=1, dirty=0; go to IDLE.
  - The held request then hits in IDLE (replay, not counted as a hit).
- Stall: p1_stall_o=1 in every non-IDLE state.
- No request: p1_data_o=0 and no state change.
- Ignored ack: mem_ack_i in IDLE or GAP is ignored.
- LRU (accessed way a with old age k):
  - age[a] becomes 0.
  - Every way with age < k increments.
  - Ages in a set always remain a permutation of 0..WAYS-1.
- Counters: saturate at all-ones; no wrap.
- Latency:
  - Hit: 0 stall cycles.
  - Clean miss: 1 + refill latency (cycles to ack) stall cycles.
  - Dirty miss: additionally write-back latency + 1 (GAP).
- Reset mid-transaction: the in-flight memory request is abandoned; mem_enable_o drops immediately; no line is written.
- Request fields: the CPU must hold p1_* stable while p1_stall_o=1. Changes during stall are undefined.

Test Plan:
- Clean miss (WAYS=2, SETS=16), after reset:
  - Stimulus: load 0x400; ack after 3 cycles with line word0 = 0xDEADBEEF.
  - Required: stall=1; mem_enable_o=1, mem_write_o=0, mem_addr_o=0x400; one cycle after ack stall=0, p1_data_o=0xDEADBEEF; miss_count_o=1, hit_count_o=0.
- Store hit:
  - Stimulus: store 0x12345678 to 0x404, then load 0x404.
  - Required: no stall; load returns 0x12345678; hit_count_o=2, miss_count_o=1.
- Dirty eviction:
  - Stimulus: after the store hit, load 0x600 (miss, fills way1); load 0x600 again; then load 0x800.
  - Required for 0x800: victim is the 0x400 line; WRITEBACK with mem_addr_o=0x400, mem_write_o=1, word1 of mem_data_o = 0x12345678; one GAP cycle with enable=0; REFILL with mem_addr_o=0x800; miss_count_o=3.
- Reset mid-REFILL:
  - Stimulus: assert rst_i while in REFILL.
  - Required: mem_enable_o=0 and p1_stall_o=0 without waiting for a clock edge; counters 0; a subsequent load 0x400 misses.
- Direct-mapped (WAYS=1):
  - Stimulus: alternate loads 0x400, 0x600, 0x400, 0x600.
  - Required: every access misses; miss_count_o=4; no write-back occurs because the lines are clean.
- Read+write simultaneous:
  - Stimulus: p1_MemRead_i=p1_MemWrite_i=1 with data 0xA5A5A5A5 to a hit address; then load the same address.
  - Required: the line is stored and marked dirty; the load returns 0xA5A5A5A5.

Source files
------------

// File: rtl/dcache_sa.sv
// Write-back, write-allocate, N-way set-associative data cache with true-LRU replacement,
// sitting between the MEM stage (p1_*) and line-wide data memory (mem_*), with hit/miss counters.
//
// state     | meaning
// ----------+------------------------------------------------------------------
// IDLE      | serve hits with no stall; on a miss pick a victim and leave
// WRITEBACK | dirty victim line held on mem_* until memory acknowledges
// GAP       | one cycle with the memory request dropped between two transfers
// REFILL    | requested line fetched; on ack it is installed and the request replays

module dcache_sa #(
    parameter int WAYS      = 2,
    parameter int SETS      = 16,
    parameter int LINE_BITS = 256,
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_W-1:0]    p1_addr_i,
    input  logic [31:0]          p1_data_i,
    input  logic                 p1_MemRead_i,
    input  logic                 p1_MemWrite_i,
    output logic [31:0]          p1_data_o,
    output logic                 p1_stall_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [CNT_W-1:0]     hit_count_o,
    output logic [CNT_W-1:0]     miss_count_o
);

    localparam int OFF   = $clog2(LINE_BITS / 8);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFF - IDX;
    localparam int WSEL  = OFF - 2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int AGE_W = WAY_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, GAP, REFILL} state_t;

    state_t state_q, state_d;

    logic                 valid_q [SETS][WAYS];
    logic                 dirty_q [SETS][WAYS];
    logic [AGE_W-1:0]     age_q   [SETS][WAYS];
    logic [TAG_W-1:0]     tag_q   [SETS][WAYS];
    logic [LINE_BITS-1:0] line_q  [SETS][WAYS];

    logic [WAY_W-1:0] victim_q;
    logic [TAG_W-1:0] req_tag_q;
    logic             replay_q;
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;

    logic [TAG_W-1:0]     req_tag;
    logic [IDX-1:0]       idx;
    logic [WSEL-1:0]      word;
    logic                 is_req;
    logic                 is_store;
    logic                 addr_unused;
    logic                 hit;
    logic [WAY_W-1:0]     hit_way;
    logic [WAY_W-1:0]     victim;
    logic                 victim_found;
    logic [LINE_BITS-1:0] hit_line;
    logic [31:0]          rd_word;
    logic                 hit_upd;
    logic                 miss_start;
    logic                 refill_done;

    assign req_tag     = p1_addr_i[ADDR_W-1:OFF+IDX];
    assign idx         = p1_addr_i[OFF+IDX-1:OFF];
    assign word        = p1_addr_i[OFF-1:2];
    assign addr_unused = ^p1_addr_i[1:0];
    assign is_req      = p1_MemRead_i | p1_MemWrite_i;
    assign is_store    = p1_MemWrite_i;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Empty ways fill lowest-first; only a full set evicts its least recently used way.
    always_comb begin
        victim       = '0;
        victim_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && !valid_q[idx][w]) begin
                victim       = WAY_W'(w);
                victim_found = 1'b1;
            end
        end
        if (!victim_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[idx][w] == AGE_W'(WAYS - 1)) begin
                    victim = WAY_W'(w);
                end
            end
        end
    end

    assign hit_line = line_q[idx][hit_way];
    assign rd_word  = hit_line[{word, 5'd0} +: 32];

    always_comb begin
        state_d      = state_q;
        p1_stall_o   = 1'b0;
        p1_data_o    = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        hit_upd      = 1'b0;
        miss_start   = 1'b0;
        refill_done  = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by rst_i so the pipeline is released the moment reset rises.
                if (is_req && !rst_i) begin
                    if (hit) begin
                        hit_upd = 1'b1;
                        if (!is_store) begin
                            p1_data_o = rd_word;
                        end
                    end else begin
                        p1_stall_o = 1'b1;
                        miss_start = 1'b1;
                        if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
                            state_d = WRITEBACK;
                        end else begin
                            state_d = REFILL;
                        end
                    end
                end
            end
            WRITEBACK: begin
                p1_stall_o   = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_q[idx][victim_q], idx, {OFF{1'b0}}};
                mem_data_o   = line_q[idx][victim_q];
                if (mem_ack_i) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                p1_stall_o = 1'b1;
                state_d    = REFILL;
            end
            REFILL: begin
                p1_stall_o   = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_tag_q, idx, {OFF{1'b0}}};
                if (mem_ack_i) begin
                    refill_done = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            victim_q   <= '0;
            req_tag_q  <= '0;
            replay_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= AGE_W'(w);
                end
            end
        end else begin
            state_q <= state_d;
            if (hit_upd) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == hit_way) begin
                        age_q[idx][w] <= '0;
                    end else if (age_q[idx][w] < age_q[idx][hit_way]) begin
                        age_q[idx][w] <= age_q[idx][w] + 1'b1;
                    end
                end
                if (is_store) begin
                    dirty_q[idx][hit_way] <= 1'b1;
                end
                // The hit that completes a miss was already counted as that miss.
                if (replay_q) begin
                    replay_q <= 1'b0;
                end else if (hit_cnt_q != '1) begin
                    hit_cnt_q <= hit_cnt_q + 1'b1;
                end
            end
            if (miss_start) begin
                replay_q  <= 1'b1;
                victim_q  <= victim;
                req_tag_q <= req_tag;
                if (miss_cnt_q != '1) begin
                    miss_cnt_q <= miss_cnt_q + 1'b1;
                end
            end
            if (refill_done) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
            end
        end
    end

    // Tag and line storage need no reset: they are only observed through valid bits.
    always_ff @(posedge clk_i) begin
        if (hit_upd && is_store) begin
            line_q[idx][hit_way][{word, 5'd0} +: 32] <= p1_data_i;
        end
        if (refill_done) begin
            line_q[idx][victim_q] <= mem_data_i;
            tag_q[idx][victim_q]  <= req_tag_q;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_dcache_sa.sv
// Randomized bench for dcache_sa: a 2-way and a direct-mapped instance checked against a
// recency-list cache model, an architectural word memory and a backing line memory.

module tb_dcache_sa;

    logic         clk;
    logic         rst_i;
    logic [31:0]  p1_addr;
    logic [31:0]  p1_wdata;
    logic         p1_rd;
    logic         p1_wr;
    logic [255:0] mem_rdata;
    logic         mem_ack;

    logic [31:0]  sa_data, dm_data;
    logic         sa_stall, dm_stall;
    logic [255:0] sa_mdata, dm_mdata;
    logic [31:0]  sa_maddr, dm_maddr;
    logic         sa_en, dm_en;
    logic         sa_mwr, dm_mwr;
    logic [31:0]  sa_hits, sa_misses;
    logic [2:0]   dm_hits, dm_misses;

    bit           sel;
    logic [31:0]  cur_data, cur_maddr, cur_hits, cur_misses;
    logic         cur_stall, cur_en, cur_mwr;
    logic [255:0] cur_mdata;

    int n_checks = 0;
    int n_errors = 0;

    dcache_sa #(.WAYS(2), .SETS(16), .LINE_BITS(256), .ADDR_W(32), .CNT_W(32)) u_sa (
        .clk_i(clk), .rst_i(rst_i),
        .p1_addr_i(p1_addr), .p1_data_i(p1_wdata), .p1_MemRead_i(p1_rd), .p1_MemWrite_i(p1_wr),
        .p1_data_o(sa_data), .p1_stall_o(sa_stall),
        .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
        .mem_data_o(sa_mdata), .mem_addr_o(sa_maddr), .mem_enable_o(sa_en), .mem_write_o(sa_mwr),
        .hit_count_o(sa_hits), .miss_count_o(sa_misses)
    );

    dcache_sa #(.WAYS(1), .SETS(16), .LINE_BITS(256), .ADDR_W(32), .CNT_W(3)) u_dm (
        .clk_i(clk), .rst_i(rst_i),
        .p1_addr_i(p1_addr), .p1_data_i(p1_wdata), .p1_MemRead_i(p1_rd), .p1_MemWrite_i(p1_wr),
        .p1_data_o(dm_data), .p1_stall_o(dm_stall),
        .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
        .mem_data_o(dm_mdata), .mem_addr_o(dm_maddr), .mem_enable_o(dm_en), .mem_write_o(dm_mwr),
        .hit_count_o(dm_hits), .miss_count_o(dm_misses)
    );

    assign cur_data   = sel ? dm_data   : sa_data;
    assign cur_stall  = sel ? dm_stall  : sa_stall;
    assign cur_mdata  = sel ? dm_mdata  : sa_mdata;
    assign cur_maddr  = sel ? dm_maddr  : sa_maddr;
    assign cur_en     = sel ? dm_en     : sa_en;
    assign cur_mwr    = sel ? dm_mwr    : sa_mwr;
    assign cur_hits   = sel ? {29'd0, dm_hits}   : sa_hits;
    assign cur_misses = sel ? {29'd0, dm_misses} : sa_misses;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-set recency list (index 0 = most recent), architectural
    // word values as the CPU sees them, and the line memory as written back by the DUT.
    int          m_ways;
    longint      cnt_max;
    logic [22:0] m_tag   [16][8];
    bit          m_dirty [16][8];
    int          m_cnt   [16];
    int          m_hits, m_misses;
    logic [31:0] arch    [int unsigned];
    logic [31:0] backing [int unsigned];

    logic [31:0]  last_wb_addr;
    logic [255:0] last_wb_line;
    int           last_stalls;
    logic [31:0]  rdata;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int unsigned wa);
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] arch_rd(input int unsigned wa);
        return arch.exists(wa) ? arch[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] back_rd(input int unsigned wa);
        return backing.exists(wa) ? backing[wa] : init_word(wa);
    endfunction

    function automatic logic [255:0] arch_line(input int unsigned ln);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = arch_rd(ln * 8 + i);
        return l;
    endfunction

    function automatic logic [255:0] back_line(input int unsigned ln);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = back_rd(ln * 8 + i);
        return l;
    endfunction

    function automatic int m_find(input int s, input logic [22:0] t);
        for (int p = 0; p < m_cnt[s]; p++) if (m_tag[s][p] == t) return p;
        return -1;
    endfunction

    function automatic void m_touch(input int s, input int p);
        logic [22:0] t;
        bit d;
        t = m_tag[s][p];
        d = m_dirty[s][p];
        for (int i = p; i > 0; i--) begin
            m_tag[s][i]   = m_tag[s][i-1];
            m_dirty[s][i] = m_dirty[s][i-1];
        end
        m_tag[s][0]   = t;
        m_dirty[s][0] = d;
    endfunction

    function automatic void m_insert(input int s, input logic [22:0] t);
        if (m_cnt[s] < m_ways) m_cnt[s]++;
        for (int i = m_cnt[s] - 1; i > 0; i--) begin
            m_tag[s][i]   = m_tag[s][i-1];
            m_dirty[s][i] = m_dirty[s][i-1];
        end
        m_tag[s][0]   = t;
        m_dirty[s][0] = 1'b0;
    endfunction

    function automatic logic [31:0] sat(input int n);
        return (longint'(n) > cnt_max) ? 32'(cnt_max) : 32'(n);
    endfunction

    // Dirty lines vanish on reset, so the architectural view falls back to memory.
    function automatic void model_reset();
        for (int s = 0; s < 16; s++) m_cnt[s] = 0;
        m_hits   = 0;
        m_misses = 0;
        arch.delete();
        foreach (backing[k]) arch[k] = backing[k];
    endfunction

    task automatic do_reset();
        rst_i   = 1'b1;
        p1_rd   = 1'b0;
        p1_wr   = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("rst_stall",  256'(cur_stall),  256'(0));
        chk("rst_data",   256'(cur_data),   256'(0));
        chk("rst_enable", 256'(cur_en),     256'(0));
        chk("rst_mwrite", 256'(cur_mwr),    256'(0));
        chk("rst_maddr",  256'(cur_maddr),  256'(0));
        chk("rst_mdata",  cur_mdata,        256'(0));
        chk("rst_hits",   256'(cur_hits),   256'(0));
        chk("rst_misses", 256'(cur_misses), 256'(0));
        @(posedge clk);
        #1 rst_i = 1'b0;
        model_reset();
    endtask

    // Called 1ns after a rising edge; returns at the same phase after the access completes.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd_out);
        int s, p, stalls, exp_stalls, lat, guard;
        logic [22:0] tg, wb_tag;
        bit exp_hit, exp_wb, in_txn, gap_chk, wb_seen;
        int unsigned wa, ln;
        s       = int'(addr[8:5]);
        tg      = addr[31:9];
        wa      = addr >> 2;
        ln      = addr >> 5;
        p       = m_find(s, tg);
        exp_hit = (p >= 0);
        exp_wb  = !exp_hit && (m_cnt[s] == m_ways) && m_dirty[s][m_ways-1];
        wb_tag  = m_tag[s][m_ways-1];
        p1_rd = rd; p1_wr = wr; p1_addr = addr; p1_wdata = wdata;
        stalls = 0; exp_stalls = 1; lat = 0; guard = 0;
        in_txn = 0; gap_chk = 0; wb_seen = 0;
        @(negedge clk);
        chk("stall_first", 256'(cur_stall), 256'(!exp_hit));
        while (cur_stall) begin
            guard++;
            if (guard > 60) begin
                chk("stall_timeout", 256'(1), 256'(0));
                break;
            end
            stalls++;
            if (gap_chk) begin
                chk("gap_enable", 256'(cur_en), 256'(0));
                gap_chk = 0;
            end else if (cur_en) begin
                if (!in_txn) begin
                    in_txn = 1;
                    lat    = $urandom_range(0, 3);
                    if (cur_mwr) begin
                        wb_seen = 1;
                        exp_stalls += lat + 2;
                        chk("wb_addr", 256'(cur_maddr), 256'({wb_tag, addr[8:5], 5'b0}));
                        chk("wb_line", cur_mdata, arch_line({5'd0, wb_tag, addr[8:5]}));
                        last_wb_addr = cur_maddr;
                        last_wb_line = cur_mdata;
                    end else begin
                        exp_stalls += lat + 1;
                        chk("rf_addr", 256'(cur_maddr), 256'({addr[31:5], 5'b0}));
                    end
                end
                if (lat == 0) begin
                    if (cur_mwr) begin
                        for (int i = 0; i < 8; i++)
                            backing[(cur_maddr >> 2) + i] = cur_mdata[i*32 +: 32];
                        gap_chk = 1;
                    end else begin
                        mem_rdata = back_line(ln);
                    end
                    mem_ack = 1'b1;
                    in_txn  = 0;
                end else begin
                    lat--;
                end
            end
            @(negedge clk);
            mem_ack = 1'b0;
        end
        chk("stall_cycles", 256'(stalls), 256'(exp_hit ? 0 : exp_stalls));
        chk("writeback", 256'(wb_seen), 256'(exp_wb));
        rd_out = cur_data;
        if (rd && !wr) chk("load_data", 256'(cur_data), 256'(arch_rd(wa)));
        if (exp_hit) begin
            m_hits++;
            m_touch(s, p);
        end else begin
            m_misses++;
            m_insert(s, tg);
        end
        if (wr) begin
            arch[wa]      = wdata;
            m_dirty[s][0] = 1'b1;
        end
        last_stalls = stalls;
        @(posedge clk);
        #1;
        p1_rd = 1'b0;
        p1_wr = 1'b0;
        #1;
        chk("idle_data", 256'(cur_data), 256'(0));
        chk("hit_count", 256'(cur_hits), 256'(sat(m_hits)));
        chk("miss_count", 256'(cur_misses), 256'(sat(m_misses)));
    endtask

    initial begin
        int kind, guard;
        logic [31:0] a;
        sel = 0; m_ways = 2; cnt_max = 64'h0000_0000_FFFF_FFFF;
        rst_i = 1'b1; p1_rd = 0; p1_wr = 0; p1_addr = '0; p1_wdata = '0;
        mem_rdata = '0; mem_ack = 0;
        last_wb_addr = '0; last_wb_line = '0;
        backing[32'h400 >> 2] = 32'hDEAD_BEEF;
        do_reset();

        access(1, 0, 32'h400, 0, rdata);
        chk("tp_clean_data", 256'(rdata), 256'(32'hDEAD_BEEF));
        chk("tp_clean_misses", 256'(cur_misses), 256'(1));
        chk("tp_clean_hits", 256'(cur_hits), 256'(0));

        access(0, 1, 32'h404, 32'h1234_5678, rdata);
        access(1, 0, 32'h404, 0, rdata);
        chk("tp_store_load", 256'(rdata), 256'(32'h1234_5678));
        chk("tp_store_nostall", 256'(last_stalls), 256'(0));
        chk("tp_store_hits", 256'(cur_hits), 256'(2));
        chk("tp_store_misses", 256'(cur_misses), 256'(1));

        access(1, 0, 32'h600, 0, rdata);
        access(1, 0, 32'h600, 0, rdata);
        last_wb_addr = '0;
        access(1, 0, 32'h800, 0, rdata);
        chk("tp_evict_addr", 256'(last_wb_addr), 256'(32'h400));
        chk("tp_evict_word1", 256'(last_wb_line[63:32]), 256'(32'h1234_5678));
        chk("tp_evict_misses", 256'(cur_misses), 256'(3));

        access(1, 1, 32'h608, 32'hA5A5_A5A5, rdata);
        access(1, 0, 32'h608, 0, rdata);
        chk("tp_rw_load", 256'(rdata), 256'(32'hA5A5_A5A5));
        access(1, 0, 32'hA00, 0, rdata);
        last_wb_addr = '0;
        access(1, 0, 32'hC00, 0, rdata);
        chk("tp_rw_dirty_addr", 256'(last_wb_addr), 256'(32'h600));
        chk("tp_rw_dirty_word", 256'(last_wb_line[95:64]), 256'(32'hA5A5_A5A5));

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 2);
            a = ($urandom_range(0, 5) << 9) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
            access(kind != 1, kind != 0, a, $urandom, rdata);
        end

        do_reset();
        p1_addr = 32'h400; p1_rd = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!cur_en && guard < 10) begin
            guard++;
            @(negedge clk);
        end
        chk("mid_rf_enable", 256'(cur_en), 256'(1));
        chk("mid_rf_mwrite", 256'(cur_mwr), 256'(0));
        #1 rst_i = 1'b1;
        #1;
        chk("mid_rst_enable", 256'(cur_en), 256'(0));
        chk("mid_rst_stall", 256'(cur_stall), 256'(0));
        chk("mid_rst_hits", 256'(cur_hits), 256'(0));
        chk("mid_rst_misses", 256'(cur_misses), 256'(0));
        model_reset();
        @(posedge clk);
        #1 rst_i = 1'b0;
        p1_rd = 1'b0;
        access(1, 0, 32'h400, 0, rdata);
        chk("post_rst_miss", 256'(cur_misses), 256'(1));

        sel = 1; m_ways = 1; cnt_max = 7;
        do_reset();
        for (int n = 0; n < 4; n++) access(1, 0, (n % 2 == 0) ? 32'h400 : 32'h600, 0, rdata);
        chk("dm_misses", 256'(cur_misses), 256'(4));
        for (int n = 0; n < 4; n++) access(1, 0, (n % 2 == 0) ? 32'h400 : 32'h600, 0, rdata);
        chk("dm_miss_sat", 256'(cur_misses), 256'(7));
        access(1, 0, 32'h604, 0, rdata);
        chk("dm_hit", 256'(cur_hits), 256'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
